// File: rtl/ps2_keys_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ps2_keys_pkg
//  Description : Shared PS/2 set-2 scancode constants, keymap controller
//                state encoding and keymap ROM address field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_keys_pkg;

    // Prefix and modifier scancodes (PS/2 set 2)
    localparam logic [7:0] c_SC_EXT    = 8'hE0;
    localparam logic [7:0] c_SC_BRK    = 8'hF0;
    localparam logic [7:0] c_SC_LSHIFT = 8'h12;
    localparam logic [7:0] c_SC_RSHIFT = 8'h59;
    localparam logic [7:0] c_SC_CAPS   = 8'h58;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Keymap ROM address layout: {ext, caps, shift, code[7:0]}
    localparam int c_ADDR_EXT_BIT   = 10;
    localparam int c_ADDR_CAPS_BIT  = 9;
    localparam int c_ADDR_SHIFT_BIT = 8;
    localparam int c_ADDR_CODE_LSB  = 0;
    localparam int c_CODE_W         = 8;

endpackage
`default_nettype wire

// File: rtl/char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : char_fifo
//  Description : Small register-based FIFO with a combinational head output.
//                A push into a full FIFO succeeds only when a pop happens in
//                the same cycle; a pop on an empty FIFO is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == c_CNT_FULL);
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = push && (!full || w_do_pop);

    // Storage, power-of-two pointer wrap and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_keymap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keymap_ctrl
//  Description : Turns PS/2 set-2 scancode bytes into keymap ROM lookups.
//                Tracks E0/F0 prefixes, shift and caps-lock state, forms the
//                {ext,caps,shift,code} ROM address, captures the registered
//                ROM output and queues non-zero ASCII codes in a FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_keymap_ctrl
    import ps2_keys_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         ADDR_W     = 11,
    parameter logic [7:0] SC_LSHIFT  = c_SC_LSHIFT,
    parameter logic [7:0] SC_RSHIFT  = c_SC_RSHIFT,
    parameter logic [7:0] SC_CAPS    = c_SC_CAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sc_data,
    input  logic              sc_valid,
    output logic              sc_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_dout,
    output logic [7:0]        char_data,
    output logic              char_avail,
    input  logic              char_rd,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              caps_led
);

    state_t r_state;
    state_t w_next_state;

    logic r_ext;
    logic r_brk;
    logic r_shift_l;
    logic r_shift_r;
    logic r_caps;
    logic r_caps_held;
    logic r_overflow;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] w_lookup_addr;

    logic w_accept;
    logic w_is_ext;
    logic w_is_brk;
    logic w_is_lshift;
    logic w_is_rshift;
    logic w_is_caps;
    logic w_start_lookup;
    logic w_push_req;
    logic w_drop;
    logic w_fifo_full;
    logic w_fifo_empty;

    assign sc_ready   = (r_state == ST_IDLE);
    assign w_accept   = sc_valid && sc_ready;
    assign w_is_ext   = (sc_data == c_SC_EXT);
    assign w_is_brk   = (sc_data == c_SC_BRK);
    // Modifier keys only count in their non-extended form; E0 12 / E0 59
    // fall through to an ordinary extended lookup.
    assign w_is_lshift = !r_ext && (sc_data == SC_LSHIFT);
    assign w_is_rshift = !r_ext && (sc_data == SC_RSHIFT);
    assign w_is_caps   = !r_ext && (sc_data == SC_CAPS);

    assign w_start_lookup = w_accept && !w_is_ext && !w_is_brk && !r_brk &&
                            !w_is_lshift && !w_is_rshift && !w_is_caps;

    // Capture happens one cycle after the ROM sampled the stable address
    assign w_push_req = (r_state == ST_CAPTURE) && (rom_dout != 8'h00);
    assign w_drop     = w_push_req && w_fifo_full && !char_rd;

    assign rom_addr = r_rom_addr;
    assign overflow = r_overflow;
    assign caps_led = r_caps;

    // Assemble the lookup address from current modifier state and the byte
    always_comb begin
        w_lookup_addr = '0;
        w_lookup_addr[c_ADDR_CODE_LSB +: c_CODE_W] = sc_data;
        w_lookup_addr[c_ADDR_SHIFT_BIT]            = r_shift_l | r_shift_r;
        w_lookup_addr[c_ADDR_CAPS_BIT]             = r_caps;
        w_lookup_addr[c_ADDR_EXT_BIT]              = r_ext;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: IDLE -> LOOKUP -> CAPTURE -> IDLE for mapped make codes
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (w_start_lookup) w_next_state = ST_LOOKUP;
            ST_LOOKUP:  w_next_state = ST_CAPTURE;
            ST_CAPTURE: w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Prefix and modifier tracking on every accepted byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_shift_l   <= 1'b0;
            r_shift_r   <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_accept) begin
            if (w_is_ext) begin
                r_ext <= 1'b1;
            end else if (w_is_brk) begin
                r_brk <= 1'b1;
            end else if (r_brk) begin
                if (w_is_lshift) r_shift_l   <= 1'b0;
                if (w_is_rshift) r_shift_r   <= 1'b0;
                if (w_is_caps)   r_caps_held <= 1'b0;
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else begin
                if (w_is_lshift) r_shift_l <= 1'b1;
                if (w_is_rshift) r_shift_r <= 1'b1;
                // Typematic repeats of caps keep caps_held set and do not toggle
                if (w_is_caps) begin
                    if (!r_caps_held) r_caps <= ~r_caps;
                    r_caps_held <= 1'b1;
                end
                r_ext <= 1'b0;
            end
        end
    end

    // Latch the ROM address when a lookup starts; held through CAPTURE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rom_addr <= '0;
        end else if (w_start_lookup) begin
            r_rom_addr <= w_lookup_addr;
        end
    end

    // Sticky overflow; a drop in the same cycle beats the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push_req),
        .push_data (rom_dout),
        .pop       (char_rd),
        .head      (char_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign char_avail = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keymap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keymap_ctrl
//  Description : Self-checking bench for ps2_keymap_ctrl with a behavioural
//                keymap ROM, directed vector table, FIFO corner sequences and
//                a randomized phase against a byte-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keymap_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  sc_data;
    logic        sc_valid;
    logic        sc_ready;
    logic [10:0] rom_addr;
    logic [7:0]  rom_dout;
    logic [7:0]  char_data;
    logic        char_avail;
    logic        char_rd;
    logic        overflow;
    logic        ovf_clr;
    logic        caps_led;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [2048];

    // Reference model state
    logic       m_ext, m_brk, m_shl, m_shr, m_caps, m_held, m_ovf;
    logic [7:0] q [$];

    typedef struct {
        logic [7:0]  sc;
        logic        lk;
        logic [10:0] addr;
        logic [7:0]  ch;
        logic        caps;
    } vec_t;

    vec_t tbl [26];

    ps2_keymap_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sc_data    (sc_data),
        .sc_valid   (sc_valid),
        .sc_ready   (sc_ready),
        .rom_addr   (rom_addr),
        .rom_dout   (rom_dout),
        .char_data  (char_data),
        .char_avail (char_avail),
        .char_rd    (char_rd),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .caps_led   (caps_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keymap ROM with one-cycle registered read
    always @(posedge clk) rom_dout <= mem[rom_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Send one byte from a negedge; returns rom_addr seen in the cycle after
    // accept and the number of cycles sc_ready stayed low. Ends on a negedge.
    task automatic send(input logic [7:0] b, output logic [10:0] a, output int busy);
        int n = 0;
        while (!sc_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        sc_data  = b;
        sc_valid = 1'b1;
        @(posedge clk);
        #1 sc_valid = 1'b0;
        @(negedge clk);
        a    = rom_addr;
        busy = 0;
        while (!sc_ready && busy < 8) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= 8 || n >= 8) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got sc_ready=0 required 1 within 8 cycles");
        end
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        chk({name, "_avail"}, 32'(char_avail), 32'd1);
        chk({name, "_data"}, 32'(char_data), 32'(exp));
        char_rd = 1'b1;
        @(negedge clk);
        char_rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0;
        m_caps = 0; m_held = 0; m_ovf = 0;
        q.delete();
    endtask

    // Byte-level interpretation of the scancode stream
    task automatic model_byte(input logic [7:0] b, output logic lk, output logic [10:0] a);
        int code;
        lk = 1'b0;
        a  = '0;
        code = int'(b);
        if (code == 'hE0) m_ext = 1;
        else if (code == 'hF0) m_brk = 1;
        else if (m_brk) begin
            if (!m_ext && code == 'h12) m_shl = 0;
            if (!m_ext && code == 'h59) m_shr = 0;
            if (!m_ext && code == 'h58) m_held = 0;
            m_ext = 0;
            m_brk = 0;
        end else begin
            if (!m_ext && code == 'h12) m_shl = 1;
            else if (!m_ext && code == 'h59) m_shr = 1;
            else if (!m_ext && code == 'h58) begin
                if (!m_held) m_caps = !m_caps;
                m_held = 1;
            end else begin
                lk = 1'b1;
                a  = 11'(1024 * int'(m_ext) + 512 * int'(m_caps) +
                         256 * int'(m_shl | m_shr) + code);
                if (mem[a] != 8'h00) begin
                    if (q.size() < 4) q.push_back(mem[a]);
                    else m_ovf = 1;
                end
            end
            m_ext = 0;
        end
    endtask

    initial begin
        logic [10:0] a;
        logic [10:0] ma;
        logic        lk;
        int          busy;
        logic [7:0]  fcodes [5];
        logic [7:0]  fchars [5];
        logic [7:0]  b;

        rst = 1'b1; sc_data = 8'h00; sc_valid = 1'b0; char_rd = 1'b0; ovf_clr = 1'b0;

        for (int i = 0; i < 2048; i++) begin
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        end
        mem[11'h01C] = 8'h61; mem[11'h11C] = 8'h41; mem[11'h21C] = 8'h41;
        mem[11'h475] = 8'h1E; mem[11'h00E] = 8'h00; mem[11'h412] = 8'h00;
        fcodes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        fchars = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74};
        for (int i = 0; i < 5; i++) mem[11'(fcodes[i])] = fchars[i];
        mem[11'h035] = 8'h79;
        mem[11'h03C] = 8'h75;

        tbl[0]  = '{8'h1C, 1'b1, 11'h01C, 8'h61, 1'b0};
        tbl[1]  = '{8'h12, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[2]  = '{8'h1C, 1'b1, 11'h11C, 8'h41, 1'b0};
        tbl[3]  = '{8'hF0, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[4]  = '{8'h12, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[5]  = '{8'h1C, 1'b1, 11'h01C, 8'h61, 1'b0};
        tbl[6]  = '{8'h58, 1'b0, 11'h000, 8'h00, 1'b1};
        tbl[7]  = '{8'h58, 1'b0, 11'h000, 8'h00, 1'b1};
        tbl[8]  = '{8'hF0, 1'b0, 11'h000, 8'h00, 1'b1};
        tbl[9]  = '{8'h58, 1'b0, 11'h000, 8'h00, 1'b1};
        tbl[10] = '{8'h1C, 1'b1, 11'h21C, 8'h41, 1'b1};
        tbl[11] = '{8'h58, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[12] = '{8'hF0, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[13] = '{8'h58, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[14] = '{8'hE0, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[15] = '{8'h75, 1'b1, 11'h475, 8'h1E, 1'b0};
        tbl[16] = '{8'hE0, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[17] = '{8'hF0, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[18] = '{8'h75, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[19] = '{8'h1C, 1'b1, 11'h01C, 8'h61, 1'b0};
        tbl[20] = '{8'h0E, 1'b1, 11'h00E, 8'h00, 1'b0};
        tbl[21] = '{8'hE0, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[22] = '{8'h12, 1'b1, 11'h412, 8'h00, 1'b0};
        tbl[23] = '{8'h1C, 1'b1, 11'h01C, 8'h61, 1'b0};
        tbl[24] = '{8'h59, 1'b0, 11'h000, 8'h00, 1'b0};
        tbl[25] = '{8'h1C, 1'b1, 11'h11C, 8'h41, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_sc_ready",   32'(sc_ready),   32'd1);
        chk("rst_char_avail", 32'(char_avail), 32'd0);
        chk("rst_char_data",  32'(char_data),  32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        chk("rst_caps_led",   32'(caps_led),   32'd0);
        chk("rst_rom_addr",   32'(rom_addr),   32'd0);

        // Directed vector table; FIFO drained after every character
        for (int i = 0; i < 26; i++) begin
            send(tbl[i].sc, a, busy);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), tbl[i].lk ? 32'd2 : 32'd0);
            if (tbl[i].lk) chk($sformatf("tbl%0d_addr", i), 32'(a), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_caps", i), 32'(caps_led), 32'(tbl[i].caps));
            chk($sformatf("tbl%0d_avail", i), 32'(char_avail), 32'(tbl[i].ch != 8'h00));
            if (tbl[i].ch != 8'h00) begin
                pop_chk($sformatf("tbl%0d_char", i), tbl[i].ch);
                chk($sformatf("tbl%0d_drained", i), 32'(char_avail), 32'd0);
            end
        end

        // Reset during LOOKUP discards the pending char and clears caps
        do_reset();
        send(8'h58, a, busy);
        chk("rl_caps_on", 32'(caps_led), 32'd1);
        sc_data = 8'h1C; sc_valid = 1'b1;
        @(posedge clk);
        #1 sc_valid = 1'b0;
        @(negedge clk);
        chk("rl_in_lookup", 32'(sc_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rl_sc_ready", 32'(sc_ready), 32'd1);
        chk("rl_caps_led", 32'(caps_led), 32'd0);
        chk("rl_avail", 32'(char_avail), 32'd0);
        repeat (3) @(negedge clk);
        chk("rl_avail_late", 32'(char_avail), 32'd0);
        send(8'h58, a, busy);
        chk("rl_caps_retoggle", 32'(caps_led), 32'd1);

        // FIFO fill past depth, overflow, coincident pop/push, clear priority
        do_reset();
        for (int i = 0; i < 5; i++) send(fcodes[i], a, busy);
        chk("ff_overflow", 32'(overflow), 32'd1);
        chk("ff_head", 32'(char_data), 32'h71);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ff_ovf_clr", 32'(overflow), 32'd0);
        sc_data = 8'h35; sc_valid = 1'b1;
        @(posedge clk);
        #1 sc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        char_rd = 1'b1;
        @(negedge clk);
        char_rd = 1'b0;
        chk("ff_coinc_no_ovf", 32'(overflow), 32'd0);
        chk("ff_coinc_ready", 32'(sc_ready), 32'd1);
        sc_data = 8'h3C; sc_valid = 1'b1;
        @(posedge clk);
        #1 sc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ff_set_beats_clr", 32'(overflow), 32'd1);
        pop_chk("ff_pop0", 8'h77);
        pop_chk("ff_pop1", 8'h65);
        pop_chk("ff_pop2", 8'h72);
        pop_chk("ff_pop3", 8'h79);
        chk("ff_empty", 32'(char_avail), 32'd0);
        char_rd = 1'b1;
        @(negedge clk);
        char_rd = 1'b0;
        send(8'h1C, a, busy);
        pop_chk("ff_after_empty_pop", 8'h61);
        chk("ff_empty2", 32'(char_avail), 32'd0);

        // Randomized stream against the reference model
        do_reset();
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                chk("rnd_avail_pre", 32'(char_avail), 32'(q.size() != 0));
                if (q.size() != 0) begin
                    chk("rnd_head_pre", 32'(char_data), 32'(q[0]));
                    void'(q.pop_front());
                end
                char_rd = 1'b1;
                @(negedge clk);
                char_rd = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                ovf_clr = 1'b1;
                @(negedge clk);
                ovf_clr = 1'b0;
                m_ovf = 0;
            end
            case ($urandom_range(0, 9))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'h12;
                3:       b = 8'h59;
                4:       b = 8'h58;
                default: b = 8'($urandom_range(1, 'h83));
            endcase
            model_byte(b, lk, ma);
            send(b, a, busy);
            chk("rnd_busy", 32'(busy), lk ? 32'd2 : 32'd0);
            if (lk) chk("rnd_addr", 32'(a), 32'(ma));
            chk("rnd_caps", 32'(caps_led), 32'(m_caps));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
            chk("rnd_avail", 32'(char_avail), 32'(q.size() != 0));
            if (q.size() != 0) chk("rnd_head", 32'(char_data), 32'(q[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
